// File: rtl/serial_capture_timer.sv
// serial_capture_timer: arms on a start handshake, hunts a serial stream for a
// sync pattern, captures a DATA_W-bit length field MSB-first, then drives a
// pulse lasting exactly that many cycles. Optionally re-arms after each frame.
//
// Handshake: start is a level request. It is sampled in IDLE (move to ARM) and
// in ARM (stay while high, proceed to DETECT once low); it is ignored elsewhere.
module serial_capture_timer #(
  parameter int                   PATTERN_W  = 4,
  parameter logic [PATTERN_W-1:0] PATTERN    = 4'b1101,
  parameter int                   DATA_W     = 8,
  parameter bit                   CONTINUOUS = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              serin,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              capturing,
  output logic              pulse_active,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] count_out,
  output logic [2:0]        state_dbg
);

  // IDLE encodes as 0 so a debug view of the reset state reads as zero.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_DETECT  = 3'd2,
    S_CAPTURE = 3'd3,
    S_LOAD    = 3'd4,
    S_COUNT   = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_MATCH = FILL_W'(PATTERN_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] COUNT_ONE  = DATA_W'(1);

  state_e              state_q;
  logic [PATTERN_W-1:0] pat_q;
  logic [FILL_W-1:0]    fill_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_W-1:0]    dat_q;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W-1:0]    count_q;

  logic [PATTERN_W-1:0] pat_d;
  logic [FILL_W-1:0]    fill_d;
  logic [DATA_W-1:0]    dat_d;
  logic                 match;

  // Next shifter contents include the current serin bit, so the final
  // pattern bit is matched in the same cycle it arrives. The fill qualifier
  // stops an all-zero pattern from matching the freshly cleared shifter.
  always_comb begin
    pat_d  = PATTERN_W'({pat_q, serin});
    dat_d  = DATA_W'({dat_q, serin});
    fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    match  = (pat_d == PATTERN) && (fill_q >= FILL_MATCH);
  end

  // Sequencer with its datapath: reset beats abort, abort beats normal flow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      dat_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else if (abort && (state_q != S_IDLE)) begin
      // Abort keeps the last captured length visible on data_out.
      state_q <= S_IDLE;
      pat_q   <= '0;
      fill_q  <= '0;
      bit_q   <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_ARM;
        end
        S_ARM: begin
          pat_q  <= '0;
          fill_q <= '0;
          bit_q  <= '0;
          if (!start) state_q <= S_DETECT;
        end
        S_DETECT: begin
          pat_q  <= pat_d;
          fill_q <= fill_d;
          if (match) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          dat_q <= dat_d;
          if (bit_q == BIT_LAST) begin
            data_q  <= dat_d;
            bit_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        S_LOAD: begin
          count_q <= data_q;
          state_q <= (data_q == '0) ? S_DONE : S_COUNT;
        end
        S_COUNT: begin
          // COUNT is only entered with a non-zero length, so no wrap.
          if (count_q == COUNT_ONE) begin
            count_q <= '0;
            state_q <= S_DONE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        S_DONE: begin
          if (CONTINUOUS) begin
            pat_q   <= '0;
            fill_q  <= '0;
            state_q <= S_DETECT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Status flags decode straight from the registered state.
  assign ready        = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign capturing    = (state_q == S_CAPTURE);
  assign pulse_active = (state_q == S_COUNT);
  assign done         = (state_q == S_DONE);
  assign data_out     = data_q;
  assign count_out    = count_q;
  assign state_dbg    = state_q;

endmodule
